// File: rtl/ac97_codec_sdata_in_tx_if.sv
// Holding-register handshakes for the AC97 codec input-frame transmitter:
// status replies and stereo ADC samples.
interface ac97_codec_sdata_in_tx_if #(
    parameter int PCM_WIDTH = 20
);
    logic                 status_valid;
    logic [6:0]           status_addr;
    logic [15:0]          status_data;
    logic                 status_ready;
    logic                 pcm_valid;
    logic [PCM_WIDTH-1:0] pcm_left;
    logic [PCM_WIDTH-1:0] pcm_right;
    logic                 pcm_ready;

    modport master (
        output status_valid, status_addr, status_data,
        input  status_ready,
        output pcm_valid, pcm_left, pcm_right,
        input  pcm_ready
    );

    modport slave (
        input  status_valid, status_addr, status_data,
        output status_ready,
        input  pcm_valid, pcm_left, pcm_right,
        output pcm_ready
    );
endinterface

// File: rtl/ac97_codec_sdata_in_tx.sv
// Codec-side AC97 sdata_in serialiser: tag, status addr/data and L/R PCM,
// aligned to the rising edge of the controller's sync.
module ac97_codec_sdata_in_tx #(
    parameter int PCM_WIDTH = 20
) (
    input  logic                           raw_bit_clk,
    input  logic                           reset_b,
    input  logic                           sync,
    input  logic                           codec_ready,
    ac97_codec_sdata_in_tx_if.slave        hs,
    output logic                           sdata_in,
    output logic                           frame_start,
    output logic                           pcm_underrun
);
    localparam int         PAD  = 20 - PCM_WIDTH;
    localparam logic [8:0] IDLE = 9'd256;

    logic        r_prev_sync;
    logic [8:0]  r_cnt;
    logic        r_sdata;
    logic        r_fs;
    logic        r_ur;

    logic        r_st_full;
    logic [6:0]  r_st_addr;
    logic [15:0] r_st_data;
    logic        r_pcm_full;
    logic [19:0] r_pcm_l;
    logic [19:0] r_pcm_r;

    logic        r_f_rdy;
    logic        r_f_st;
    logic        r_f_pcm;
    logic [6:0]  r_f_addr;
    logic [15:0] r_f_data;
    logic [19:0] r_f_l;
    logic [19:0] r_f_r;

    logic        w_start;
    logic        w_st_acc;
    logic        w_pcm_acc;
    logic        w_st_take;
    logic        w_pcm_take;
    logic [15:0] w_tag;
    logic [95:0] w_frame;
    logic [6:0]  w_idx;
    logic        w_bit;

    assign w_start    = sync & ~r_prev_sync;
    assign w_st_acc   = hs.status_valid & ~r_st_full;
    assign w_pcm_acc  = hs.pcm_valid & ~r_pcm_full;
    assign w_st_take  = w_start & codec_ready & r_st_full;
    assign w_pcm_take = w_start & codec_ready & r_pcm_full;

    assign w_tag   = {r_f_rdy, {2{r_f_st}}, {2{r_f_pcm}}, 11'd0};
    assign w_frame = {w_tag,
                      1'b0, r_f_addr, 12'h000,
                      r_f_data, 4'h0,
                      r_f_l,
                      r_f_r};
    assign w_idx   = 7'd95 - r_cnt[6:0];
    // Only slots 0..4 carry data; everything past bit 95 is zero.
    assign w_bit   = (r_cnt < 9'd96) ? w_frame[w_idx] : 1'b0;

    assign hs.status_ready = ~r_st_full;
    assign hs.pcm_ready    = ~r_pcm_full;
    assign sdata_in        = r_sdata;
    assign frame_start     = r_fs;
    assign pcm_underrun    = r_ur;

    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_prev_sync <= 1'b0;
        end else begin
            r_prev_sync <= sync;
        end
    end

    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt    <= IDLE;
            r_sdata  <= 1'b0;
            r_fs     <= 1'b0;
            r_ur     <= 1'b0;
            r_f_rdy  <= 1'b0;
            r_f_st   <= 1'b0;
            r_f_pcm  <= 1'b0;
            r_f_addr <= 7'd0;
            r_f_data <= 16'd0;
            r_f_l    <= 20'd0;
            r_f_r    <= 20'd0;
        end else if (w_start) begin
            r_cnt    <= 9'd1;
            r_sdata  <= codec_ready;
            r_fs     <= 1'b1;
            r_ur     <= codec_ready & ~r_pcm_full;
            r_f_rdy  <= codec_ready;
            r_f_st   <= w_st_take;
            r_f_pcm  <= w_pcm_take;
            r_f_addr <= w_st_take ? r_st_addr : 7'd0;
            r_f_data <= w_st_take ? r_st_data : 16'd0;
            r_f_l    <= w_pcm_take ? r_pcm_l : 20'd0;
            r_f_r    <= w_pcm_take ? r_pcm_r : 20'd0;
        end else begin
            r_fs <= 1'b0;
            r_ur <= 1'b0;
            if (r_cnt != IDLE) begin
                r_sdata <= w_bit;
                r_cnt   <= r_cnt + 9'd1;
            end else begin
                r_sdata <= 1'b0;
            end
        end
    end

    // Accept only when empty and consume only when full, so the two
    // never collide on one edge.
    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_st_full <= 1'b0;
            r_st_addr <= 7'd0;
            r_st_data <= 16'd0;
        end else if (w_st_take) begin
            r_st_full <= 1'b0;
        end else if (w_st_acc) begin
            r_st_full <= 1'b1;
            r_st_addr <= hs.status_addr;
            r_st_data <= hs.status_data;
        end
    end

    always_ff @(posedge raw_bit_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_pcm_full <= 1'b0;
            r_pcm_l    <= 20'd0;
            r_pcm_r    <= 20'd0;
        end else if (w_pcm_take) begin
            r_pcm_full <= 1'b0;
        end else if (w_pcm_acc) begin
            r_pcm_full <= 1'b1;
            r_pcm_l    <= 20'(hs.pcm_left) << PAD;
            r_pcm_r    <= 20'(hs.pcm_right) << PAD;
        end
    end
endmodule
